// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared memory-path widths and port-select enum
package cpu_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/grant/response bundle for one memory requester
interface mem_arbiter_if #(
  parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin / fixed-priority one-hot picker
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  output logic [1:0] gnt
);

  // On a conflict, prio forces req[1]; otherwise the side not granted last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (prio || !last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the shared single-port unified memory
module mem_arbiter
  import cpu_mem_pkg::port_e;
  import cpu_mem_pkg::PORT_I;
  import cpu_mem_pkg::PORT_D;
#(
  parameter int ADDR_W        = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W        = cpu_mem_pkg::DATA_W,
  parameter int DATA_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      i_port,
  mem_arbiter_if.slave      d_port,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  port_e             last_gnt;
  logic [ADDR_W-1:0] addr_q;
  logic              i_rvalid_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  assign req = reset ? 2'b00 : {d_port.req, i_port.req};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_gnt == PORT_D),
    .prio (DATA_PRIORITY != 0),
    .gnt  (gnt)
  );

  assign i_port.gnt    = gnt[0];
  assign d_port.gnt    = gnt[1];
  assign i_port.rvalid = i_rvalid_q;
  assign d_port.rvalid = d_rvalid_q;
  assign i_port.rdata  = i_rdata_q;
  assign d_port.rdata  = d_rdata_q;

  // Idle cycles replay the last granted address so the memory address bus stays quiet.
  assign mem_we   = gnt[1] & d_port.we;
  assign mem_addr = gnt[1] ? d_port.addr : (gnt[0] ? i_port.addr : addr_q);
  assign mem_din  = d_port.wdata;

  // Fetch port never writes.
  logic unused_fetch_wr;
  assign unused_fetch_wr = ^{i_port.we, i_port.wdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      last_gnt   <= PORT_I;
      addr_q     <= '0;
    end else begin
      i_rvalid_q <= gnt[0];
      d_rvalid_q <= gnt[1];
      if (gnt[0]) begin
        i_rdata_q <= mem_dout;
      end
      if (gnt[1]) begin
        d_rdata_q <= d_port.we ? '0 : mem_dout;
      end
      if (|gnt) begin
        last_gnt <= gnt[1] ? PORT_D : PORT_I;
        addr_q   <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter, both priority modes side by side
module tb_mem_arbiter;
  import cpu_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return (a == 5) ? 32'h0000_1234 : ((32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [47:0] s6(input string s);
    logic [47:0] v = '0;
    for (int k = 0; k < s.len() && k < 6; k++) v = {v[39:0], s[k]};
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_prio
    logic              reset;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem [1024];
    bit                written [1024];
    bit                done = 1'b0;
    bit                log_en = 1'b0;
    string             gseq = "";

    mem_arbiter_if ifi ();
    mem_arbiter_if ifd ();

    mem_arbiter #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .DATA_PRIORITY (g)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .i_port   (ifi),
      .d_port   (ifd),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
    );

    assign mem_dout = written[mem_addr] ? mem[mem_addr] : init_word(int'(mem_addr));
    always @(posedge clk) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_din;
        written[mem_addr] <= 1'b1;
      end
    end

    // Reference model: arbitration rules, an abstract memory image and per-port response queues.
    port_e             m_last = PORT_I;
    logic [ADDR_W-1:0] hold_addr = '0;
    bit                hold_known = 1'b0;
    logic [DATA_W-1:0] want_i_rdata = '0;
    logic [DATA_W-1:0] want_d_rdata = '0;
    logic [DATA_W-1:0] qi [$];
    logic [DATA_W-1:0] qd [$];
    logic [DATA_W-1:0] ref_mem [int];

    always @(negedge clk) begin : monitor
      port_e             win;
      bit                any;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] rv;
      string             tag;
      check($sformatf("p%0d.i_rvalid", g), 64'(ifi.rvalid), 64'(qi.size() != 0));
      if (qi.size() != 0) want_i_rdata = qi.pop_front();
      check($sformatf("p%0d.i_rdata", g), 64'(ifi.rdata), 64'(want_i_rdata));
      check($sformatf("p%0d.d_rvalid", g), 64'(ifd.rvalid), 64'(qd.size() != 0));
      if (qd.size() != 0) want_d_rdata = qd.pop_front();
      check($sformatf("p%0d.d_rdata", g), 64'(ifd.rdata), 64'(want_d_rdata));
      if (reset) begin
        check($sformatf("p%0d.rst_i_gnt", g), 64'(ifi.gnt), 64'(0));
        check($sformatf("p%0d.rst_d_gnt", g), 64'(ifd.gnt), 64'(0));
        check($sformatf("p%0d.rst_mem_we", g), 64'(mem_we), 64'(0));
        qi.delete();
        qd.delete();
        want_i_rdata = '0;
        want_d_rdata = '0;
        m_last       = PORT_I;
        hold_known   = 1'b0;
      end else begin
        any = ifi.req || ifd.req;
        if (ifi.req && ifd.req) win = (g == 1 || m_last == PORT_I) ? PORT_D : PORT_I;
        else                    win = ifd.req ? PORT_D : PORT_I;
        check($sformatf("p%0d.i_gnt", g), 64'(ifi.gnt), 64'(any && win == PORT_I));
        check($sformatf("p%0d.d_gnt", g), 64'(ifd.gnt), 64'(any && win == PORT_D));
        check($sformatf("p%0d.mem_we", g), 64'(mem_we), 64'(any && win == PORT_D && ifd.we));
        if (any) begin
          a = (win == PORT_D) ? ifd.addr : ifi.addr;
          check($sformatf("p%0d.mem_addr", g), 64'(mem_addr), 64'(a));
          if (win == PORT_D) check($sformatf("p%0d.mem_din", g), 64'(mem_din), 64'(ifd.wdata));
          rv = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(int'(a));
          if (win == PORT_D && ifd.we) begin
            qd.push_back('0);
            ref_mem[int'(a)] = ifd.wdata;
          end else if (win == PORT_D) begin
            qd.push_back(rv);
          end else begin
            qi.push_back(rv);
          end
          m_last     = win;
          hold_addr  = a;
          hold_known = 1'b1;
          if (log_en) begin
            tag  = (win == PORT_D) ? "D" : "I";
            gseq = {gseq, tag};
          end
        end else if (hold_known) begin
          check($sformatf("p%0d.idle_mem_addr", g), 64'(mem_addr), 64'(hold_addr));
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    initial begin : driver
      bit gi, gd;
      reset     = 1'b1;
      ifi.we    = 1'b0;
      ifi.wdata = '0;
      ifi.req   = 1'b1;
      ifi.addr  = 10'd1;
      ifd.req   = 1'b1;
      ifd.we    = 1'b0;
      ifd.addr  = 10'd2;
      ifd.wdata = '0;
      repeat (3) tick();
      reset  = 1'b0;
      log_en = 1'b1;
      repeat (6) tick();
      log_en  = 1'b0;
      ifi.req = 1'b0;
      ifd.req = 1'b0;
      check($sformatf("p%0d.grant_seq", g), 64'(s6(gseq)), 64'(s6((g == 0) ? "DIDIDI" : "DDDDDD")));
      tick();

      ifi.req  = 1'b1;
      ifi.addr = 10'd5;
      tick();
      ifi.req = 1'b0;
      check($sformatf("p%0d.fetch5_rvalid", g), 64'(ifi.rvalid), 64'(1));
      check($sformatf("p%0d.fetch5_rdata", g), 64'(ifi.rdata), 64'(32'h0000_1234));
      tick();

      ifd.req   = 1'b1;
      ifd.we    = 1'b1;
      ifd.addr  = 10'd7;
      ifd.wdata = 32'hDEAD_BEEF;
      tick();
      ifd.we = 1'b0;
      check($sformatf("p%0d.store_ack", g), 64'(ifd.rdata), 64'(0));
      tick();
      ifd.req = 1'b0;
      check($sformatf("p%0d.load_after_store", g), 64'(ifd.rdata), 64'(32'hDEAD_BEEF));
      tick();

      ifd.req  = 1'b1;
      ifd.addr = 10'd9;
      tick();
      ifd.req = 1'b0;
      reset   = 1'b1;
      tick();
      check($sformatf("p%0d.rst_drop_rvalid", g), 64'(ifd.rvalid), 64'(0));
      check($sformatf("p%0d.rst_drop_rdata", g), 64'(ifd.rdata), 64'(0));
      reset = 1'b0;
      tick();
      check($sformatf("p%0d.no_replay", g), 64'(ifd.rvalid), 64'(0));

      ifi.req  = 1'b1;
      ifi.addr = 10'd3;
      tick();
      ifi.req = 1'b0;
      check($sformatf("p%0d.idle_addr3", g), 64'(mem_addr), 64'(3));
      tick();
      check($sformatf("p%0d.idle_no_rvalid", g), 64'(ifi.rvalid), 64'(0));
      ifi.req  = 1'b1;
      ifi.addr = 10'd4;
      tick();
      ifi.req = 1'b0;
      tick();

      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        gi = ifi.gnt;
        gd = ifd.gnt;
        @(posedge clk);
        #1;
        reset = ($urandom_range(0, 59) == 0);
        if (!ifi.req || gi) begin
          ifi.req  = ($urandom_range(0, 2) != 0);
          ifi.addr = 10'($urandom_range(0, 15));
        end else if ($urandom_range(0, 9) == 0) begin
          ifi.req = 1'b0;
        end
        if (!ifd.req || gd) begin
          ifd.req   = ($urandom_range(0, 2) != 0);
          ifd.we    = 1'($urandom_range(0, 1));
          ifd.addr  = 10'($urandom_range(0, 15));
          ifd.wdata = $urandom;
        end else if ($urandom_range(0, 9) == 0) begin
          ifd.req = 1'b0;
        end
      end
      reset   = 1'b0;
      ifi.req = 1'b0;
      ifd.req = 1'b0;
      repeat (4) tick();
      done = 1'b1;
    end
  end

  initial begin : finisher
    bit ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      if (gen_prio[0].done && gen_prio[1].done) begin
        ok = 1'b1;
        break;
      end
    end
    check("run_complete", 64'(ok), 64'(1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
